// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus type, stall patterns, mul/div FSM states.
package pipe_ctrl_pkg;

   localparam int unsigned STALL_W = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned BCNT_W  = 6;
   localparam int unsigned SCNT_W  = 32;

   // Stall bus bit order: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
   typedef logic [STALL_W-1:0] StallBus;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam StallBus STALL_NONE    = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
   localparam StallBus STALL_LOADUSE = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
   localparam StallBus STALL_MD      = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
   localparam StallBus STALL_MEM     = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: load-use hazard, mul/div sequencing, memory wait, stall counter.
// Optional mul/div timeout enabled by defining PIPE_CTRL_MD_TIMEOUT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_re1,
   input  logic              id_re2,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              ex_load,
   input  logic [REG_W-1:0]  ex_rf_waddr,
   input  logic              ex_md_start,
   input  logic              md_ready,
   input  logic              mem_wait,
   output StallBus           stall,
   output logic              md_busy,
   output logic [SCNT_W-1:0] stall_cycles
`ifdef PIPE_CTRL_MD_TIMEOUT_EN
   ,
   output logic              md_timeout
`endif
);

`ifdef PIPE_CTRL_MD_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [BCNT_W-1:0] BCNT_MAX     = '1;
   localparam logic [BCNT_W-1:0] TIMEOUT_LAST = BCNT_W'(MD_TIMEOUT - 1);

   md_state_e         state;
   logic [BCNT_W-1:0] busy_cnt;
   logic              load_use;
   logic              md_issue;
   logic              md_accept;
   logic              timeout_hit;

   assign load_use = ex_load && (ex_rf_waddr != '0) &&
                     ((id_re1 && (id_rs == ex_rf_waddr)) ||
                      (id_re2 && (id_rt == ex_rf_waddr)));

   // Issue stalls for zero latency in IDLE or DONE; only IDLE actually accepts.
   assign md_issue    = (state != MD_BUSY) && ex_md_start && !mem_wait;
   assign md_accept   = (state == MD_IDLE) && ex_md_start && !mem_wait;
   assign timeout_hit = (state == MD_BUSY) && !md_ready && (busy_cnt == TIMEOUT_LAST);
   assign md_busy     = (state == MD_BUSY);

   // Stall priority: reset > mem_wait > mul/div > load-use
   always_comb begin
      stall = STALL_NONE;
      if (!rst)
         stall = STALL_NONE;
      else if (mem_wait)
         stall = STALL_MEM;
      else if ((state == MD_BUSY) || md_issue)
         stall = STALL_MD;
      else if (load_use)
         stall = STALL_LOADUSE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MD_IDLE;
      end else begin
         case (state)
            MD_IDLE: if (md_accept) state <= MD_BUSY;
            MD_BUSY: begin
               if (md_ready)
                  state <= MD_DONE;
               else if (TIMEOUT_EN && timeout_hit)
                  state <= MD_IDLE;
            end
            MD_DONE: state <= MD_IDLE;
            default: state <= MD_IDLE;
         endcase
      end
   end

   // Saturating BUSY-cycle counter, cleared on the edge that enters BUSY
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busy_cnt <= '0;
      else if (md_accept)
         busy_cnt <= '0;
      else if ((state == MD_BUSY) && (busy_cnt != BCNT_MAX))
         busy_cnt <= busy_cnt + BCNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (stall != STALL_NONE)
         stall_cycles <= stall_cycles + SCNT_W'(1);
   end

`ifdef PIPE_CTRL_MD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         md_timeout <= 1'b0;
      else if (timeout_hit)
         md_timeout <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        id_re1, id_re2;
   logic [4:0]  id_rs, id_rt;
   logic        ex_load;
   logic [4:0]  ex_rf_waddr;
   logic        ex_md_start;
   logic        md_ready;
   logic        mem_wait;
   logic [5:0]  stall;
   logic        md_busy;
   logic [31:0] stall_cycles;
`ifdef PIPE_CTRL_MD_TIMEOUT_EN
   logic        md_timeout;
`endif

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.MD_TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_re1       (id_re1),
      .id_re2       (id_re2),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .ex_load      (ex_load),
      .ex_rf_waddr  (ex_rf_waddr),
      .ex_md_start  (ex_md_start),
      .md_ready     (md_ready),
      .mem_wait     (mem_wait),
      .stall        (stall),
      .md_busy      (md_busy),
      .stall_cycles (stall_cycles)
`ifdef PIPE_CTRL_MD_TIMEOUT_EN
      ,
      .md_timeout   (md_timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_re1 = 0; id_re2 = 0; id_rs = 0; id_rt = 0;
      ex_load = 0; ex_rf_waddr = 0; ex_md_start = 0; md_ready = 0; mem_wait = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 0;
      @(negedge clk);
      rst = 1;
   endtask

   // Advance to the next falling edge; inputs are driven there and outputs sampled 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 0;
      mem_wait = 1; ex_md_start = 1;
      #1;
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall: got %b want 000000", stall); end
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
      checks++;
      if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
      @(negedge clk);
      clear_inputs();
      rst = 1;
      #1;
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL reset_idle_stall: got %b want 000000", stall); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_load = 1; ex_rf_waddr = 8; id_re1 = 1; id_rs = 8;
      #1;
      checks++;
      if (stall !== 6'b000111) begin errors++; $display("FAIL lu_hit_rs: got %b want 000111", stall); end
      next_cycle();
      ex_load = 0;
      #1;
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL lu_one_cycle: got %b want 000000", stall); end
      next_cycle();
      ex_load = 1; ex_rf_waddr = 0; id_rs = 0;
      #1;
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL lu_r0: got %b want 000000", stall); end
      next_cycle();
      ex_rf_waddr = 8; id_rs = 8; id_re1 = 0;
      #1;
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL lu_no_re1: got %b want 000000", stall); end
      next_cycle();
      id_re2 = 1; id_rt = 8;
      #1;
      checks++;
      if (stall !== 6'b000111) begin errors++; $display("FAIL lu_hit_rt: got %b want 000111", stall); end
      next_cycle();
      clear_inputs();
      #1;
      checks++;
      if (stall_cycles !== 32'd2) begin errors++; $display("FAIL lu_stall_cycles: got %0d want 2", stall_cycles); end
   endtask

   task automatic test_muldiv();
      logic [5:0] exp_stall [0:7];
      logic       exp_busy  [0:7];
      exp_stall = '{6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b000000, 6'b000000};
      exp_busy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         ex_md_start = (i == 0);
         md_ready    = (i == 5);
         #1;
         checks++;
         if (stall !== exp_stall[i]) begin errors++; $display("FAIL md_stall[%0d]: got %b want %b", i, stall, exp_stall[i]); end
         checks++;
         if (md_busy !== exp_busy[i]) begin errors++; $display("FAIL md_busy[%0d]: got %b want %b", i, md_busy, exp_busy[i]); end
         next_cycle();
      end
      clear_inputs();
      #1;
      checks++;
      if (stall_cycles !== 32'd6) begin errors++; $display("FAIL md_stall_cycles: got %0d want 6", stall_cycles); end
   endtask

   task automatic test_priority();
      do_reset();
      ex_md_start = 1;
      next_cycle();
      ex_md_start = 0;
      ex_load = 1; ex_rf_waddr = 8; id_re1 = 1; id_rs = 8;
      mem_wait = 1;
      #1;
      checks++;
      if (stall !== 6'b011111) begin errors++; $display("FAIL prio_mem: got %b want 011111", stall); end
      next_cycle();
      mem_wait = 0;
      #1;
      checks++;
      if (stall !== 6'b001111) begin errors++; $display("FAIL prio_md: got %b want 001111", stall); end
      next_cycle();
      md_ready = 1;
      #1;
      checks++;
      if (stall !== 6'b001111) begin errors++; $display("FAIL prio_md_ready: got %b want 001111", stall); end
      next_cycle();
      md_ready = 0;
      #1;
      checks++;
      if (stall !== 6'b000111) begin errors++; $display("FAIL prio_done_lu: got %b want 000111", stall); end
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL prio_done_busy: got %b want 0", md_busy); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_issue_gating();
      do_reset();
      ex_md_start = 1; mem_wait = 1;
      #1;
      checks++;
      if (stall !== 6'b011111) begin errors++; $display("FAIL gate_mem: got %b want 011111", stall); end
      next_cycle();
      mem_wait = 0;
      #1;
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL gate_not_accepted: got %b want 0", md_busy); end
      checks++;
      if (stall !== 6'b001111) begin errors++; $display("FAIL gate_issue: got %b want 001111", stall); end
      next_cycle();
      ex_md_start = 0;
      #1;
      checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL gate_accepted: got %b want 1", md_busy); end
      md_ready = 1;
      next_cycle();
      md_ready = 0;
      next_cycle();
      // start and ready together in IDLE: ready discarded, BUSY entered
      ex_md_start = 1; md_ready = 1;
      next_cycle();
      ex_md_start = 0; md_ready = 0;
      #1;
      checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL ready_ignored_idle: got %b want 1", md_busy); end
      next_cycle();
      #1;
      checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL still_busy: got %b want 1", md_busy); end
      next_cycle();
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      ex_md_start = 1;
      next_cycle();
      ex_md_start = 0;
      next_cycle();
      next_cycle();
      #1;
      checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL rmb_busy_c3: got %b want 1", md_busy); end
      rst = 0;
      ex_load = 1; ex_rf_waddr = 8; id_re1 = 1; id_rs = 8;
      #1;
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL rmb_stall: got %b want 000000", stall); end
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL rmb_md_busy: got %b want 0", md_busy); end
      checks++;
      if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rmb_stall_cycles: got %0d want 0", stall_cycles); end
      next_cycle();
      clear_inputs();
      rst = 1;
      md_ready = 1;
      next_cycle();
      md_ready = 0;
      #1;
      checks++;
      if ((md_busy !== 1'b0) || (stall !== 6'b000000)) begin
         errors++; $display("FAIL rmb_after: busy=%b stall=%b want 0/000000", md_busy, stall);
      end
   endtask

`ifdef PIPE_CTRL_MD_TIMEOUT_EN
   task automatic test_timeout();
      int busy_count = 0;
      do_reset();
      ex_md_start = 1;
      next_cycle();
      ex_md_start = 0;
      for (int i = 0; i < 80; i++) begin
         #1;
         if (md_busy === 1'b1) busy_count++;
         next_cycle();
      end
      checks++;
      if (busy_count !== 64) begin errors++; $display("FAIL to_busy_cycles: got %0d want 64", busy_count); end
      checks++;
      if (md_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", md_timeout); end
   endtask
`endif

   task automatic test_wrap();
      do_reset();
      force dut.stall_cycles = 32'hFFFF_FFFF;
      next_cycle();
      release dut.stall_cycles;
      mem_wait = 1;
      next_cycle();
      #1;
      checks++;
      if (stall_cycles !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", stall_cycles); end
      next_cycle();
      mem_wait = 0;
      #1;
      checks++;
      if (stall_cycles !== 32'h0000_0001) begin errors++; $display("FAIL wrap_one: got %h want 00000001", stall_cycles); end
   endtask

   initial begin
      rst = 0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_muldiv();
      test_priority();
      test_issue_gating();
      test_reset_mid_busy();
`ifdef PIPE_CTRL_MD_TIMEOUT_EN
      test_timeout();
`endif
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
